// File: rtl/kbd_pkg.sv
// Shared register map constants and decode helper for the keyboard receive port.
package kbd_pkg;

    localparam logic [4:0] KBD_DATA_OFF   = 5'h00;
    localparam logic [4:0] KBD_STATUS_OFF = 5'h08;
    localparam logic [4:0] KBD_CTRL_OFF   = 5'h10;

    localparam int unsigned STATUS_OVF_BIT  = 0;
    localparam int unsigned STATUS_FULL_BIT = 1;
    localparam int unsigned DATA_VALID_BIT  = 8;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } kbd_reg_e;

    // Registers are 64-bit, so only address bits [4:3] pick the register.
    function automatic kbd_reg_e reg_decode(input logic [4:0] off);
        kbd_reg_e r;
        if (off[4:3] == KBD_DATA_OFF[4:3])
            r = REG_DATA;
        else if (off[4:3] == KBD_STATUS_OFF[4:3])
            r = REG_STATUS;
        else if (off[4:3] == KBD_CTRL_OFF[4:3])
            r = REG_CTRL;
        else
            r = REG_RSVD;
        return r;
    endfunction

endpackage

// File: rtl/kbd_rx_mmio_sync_fifo.sv
// Synchronous FIFO with registered pointers and show-ahead output.
module sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // When full, a concurrent pop frees the slot the push writes into.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kbd_rx_mmio.sv
// Memory-mapped keyboard receive port: key-edge capture into a FIFO, DATA/STATUS/CTRL registers, level irq.
module kbd_rx_mmio
    import kbd_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0010,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ascii_code,
    input  logic        key_pressed,
    input  logic [63:0] bus_address,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    input  logic [63:0] bus_write_data,
    output logic [63:0] bus_read_data,
    output logic        bus_read_valid,
    output logic        irq,
    output logic        overflow
);

    logic                key_pressed_d;
    logic                push;
    logic                pop;
    logic                sel;
    logic                rd_hit;
    logic                wr_hit;
    kbd_reg_e            reg_sel;
    logic [7:0]          fifo_dout;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                ctrl_ie;
    logic                ovf_set;
    logic                ovf_clr;
    logic [63:0]         rd_next;
    logic                unused_bits;

    assign unused_bits = ^{bus_address[2:0], bus_write_data[63:1]};

    // Loaded even during reset so a key held across reset release is not seen as a new press.
    always_ff @(posedge clk) begin
        key_pressed_d <= key_pressed;
    end

    assign push    = key_pressed & ~key_pressed_d;
    assign sel     = (bus_address[63:5] == BASE_ADDR[63:5]);
    assign reg_sel = reg_decode(bus_address[4:0]);
    assign rd_hit  = bus_read_enable & sel;
    assign wr_hit  = bus_write_enable & sel;
    assign pop     = rd_hit & (reg_sel == REG_DATA);
    assign ovf_set = push & fifo_full & ~pop;
    assign ovf_clr = wr_hit & (reg_sel == REG_STATUS) & bus_write_data[STATUS_OVF_BIT];

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (ascii_code),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rd_next = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!fifo_empty) begin
                    rd_next[7:0]           = fifo_dout;
                    rd_next[DATA_VALID_BIT] = 1'b1;
                end
            end
            REG_STATUS: begin
                rd_next[DEPTH_LOG2+8:8]     = fifo_count;
                rd_next[STATUS_FULL_BIT]    = fifo_full;
                rd_next[STATUS_OVF_BIT]     = overflow;
            end
            REG_CTRL:  rd_next[0] = ctrl_ie;
            default:   rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_read_data  <= '0;
            bus_read_valid <= 1'b0;
            irq            <= 1'b0;
            overflow       <= 1'b0;
            ctrl_ie        <= 1'b0;
        end else begin
            bus_read_valid <= rd_hit;
            if (rd_hit)
                bus_read_data <= rd_next;
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
            if (wr_hit && reg_sel == REG_CTRL)
                ctrl_ie <= bus_write_data[0];
            irq <= ctrl_ie & ~fifo_empty;
        end
    end

endmodule

// File: tb/tb_kbd_rx_mmio.sv
// Directed self-checking bench for kbd_rx_mmio.
module tb_kbd_rx_mmio;

    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0010;
    localparam logic [63:0] WIN    = BASE & ~64'h1F;
    localparam logic [63:0] A_DATA = WIN;
    localparam logic [63:0] A_STAT = WIN + 64'h08;
    localparam logic [63:0] A_CTRL = WIN + 64'h10;
    localparam logic [63:0] A_RSVD = WIN + 64'h18;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ascii_code;
    logic        key_pressed;
    logic [63:0] bus_address;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [63:0] bus_write_data;
    logic [63:0] bus_read_data;
    logic        bus_read_valid;
    logic        irq;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    kbd_rx_mmio #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .ascii_code       (ascii_code),
        .key_pressed      (key_pressed),
        .bus_address      (bus_address),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_write_data   (bus_write_data),
        .bus_read_data    (bus_read_data),
        .bus_read_valid   (bus_read_valid),
        .irq              (irq),
        .overflow         (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [63:0] addr, output logic [63:0] data, output logic vld);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        data = bus_read_data;
        vld  = bus_read_valid;
    endtask

    task automatic wr(input logic [63:0] addr, input logic [63:0] d);
        bus_address      = addr;
        bus_write_data   = d;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic press(input logic [7:0] b, input int unsigned hold);
        ascii_code  = b;
        key_pressed = 1'b1;
        repeat (hold) tick();
        key_pressed = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] stat(input int unsigned cnt, input logic full, input logic ovf);
        return (64'(cnt) << 8) | (64'(full) << 1) | 64'(ovf);
    endfunction

    logic [63:0] d;
    logic        v;

    initial begin
        reset            = 1'b1;
        ascii_code       = 8'h00;
        key_pressed      = 1'b0;
        bus_address      = '0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        bus_write_data   = '0;
        repeat (3) tick();
        chk("reset_rdata", bus_read_data, 64'h0);
        chk("reset_rvalid", 64'(bus_read_valid), 64'h0);
        chk("reset_irq", 64'(irq), 64'h0);
        chk("reset_ovf", 64'(overflow), 64'h0);
        reset = 1'b0;
        tick();
        rd(A_STAT, d, v);
        chk("reset_status", d, stat(0, 0, 0));

        // 'A' held for 100 cycles gives exactly one entry
        press(8'h41, 100);
        rd(A_STAT, d, v);
        chk("press_A_status", d, stat(1, 0, 0));
        chk("irq_off_when_ie0", 64'(irq), 64'h0);
        rd(A_DATA, d, v);
        chk("press_A_data", d, 64'h141);
        chk("press_A_valid", 64'(v), 64'h1);
        tick();
        chk("valid_one_cycle", 64'(bus_read_valid), 64'h0);
        rd(A_STAT + 64'h5, d, v);
        chk("after_pop_status", d, stat(0, 0, 0));

        rd(A_DATA, d, v);
        chk("empty_read_data", d, 64'h0);
        chk("empty_read_valid", 64'(v), 64'h1);
        rd(A_STAT, d, v);
        chk("empty_read_count", d, stat(0, 0, 0));

        rd(A_RSVD, d, v);
        chk("rsvd_read", d, 64'h0);
        rd(WIN + 64'h20, d, v);
        chk("outside_read_valid", 64'(v), 64'h0);
        chk("outside_read_hold", d, 64'h0);
        wr(WIN + 64'h30, 64'h1);
        rd(A_CTRL, d, v);
        chk("outside_write_ignored", d, 64'h0);

        for (int i = 0; i < 17; i++) press(8'(8'h30 + i), 2);
        rd(A_STAT, d, v);
        chk("fill17_status", d, stat(16, 1, 1));
        chk("fill17_ovf_pin", 64'(overflow), 64'h1);

        // press edge coincides with a DATA pop while full
        ascii_code      = 8'h50;
        key_pressed     = 1'b1;
        bus_address     = A_DATA;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        key_pressed     = 1'b0;
        chk("full_pushpop_data", bus_read_data, 64'h130);
        tick();
        rd(A_STAT, d, v);
        chk("full_pushpop_status", d, stat(16, 1, 1));
        for (int i = 1; i < 16; i++) begin
            rd(A_DATA, d, v);
            chk("drain_seq", d, 64'h100 | 64'(8'h30 + i));
        end
        rd(A_DATA, d, v);
        chk("drain_last_new", d, 64'h150);
        rd(A_STAT, d, v);
        chk("drained_status", d, stat(0, 0, 1));
        wr(A_STAT, 64'h1);
        chk("ovf_cleared_pin", 64'(overflow), 64'h0);

        wr(A_CTRL, 64'h1);
        rd(A_CTRL, d, v);
        chk("ctrl_readback", d, 64'h1);
        ascii_code  = 8'h7A;
        key_pressed = 1'b1;
        tick();
        chk("irq_lag", 64'(irq), 64'h0);
        tick();
        chk("irq_set", 64'(irq), 64'h1);
        key_pressed = 1'b0;
        rd(A_DATA, d, v);
        chk("z_data", d, 64'h17A);
        chk("irq_still_on_pop_edge", 64'(irq), 64'h1);
        tick();
        chk("irq_clear", 64'(irq), 64'h0);

        for (int i = 0; i < 16; i++) press(8'(8'h60 + i), 2);
        rd(A_STAT, d, v);
        chk("refill_status", d, stat(16, 1, 0));
        // overflow set and clear in the same cycle
        ascii_code       = 8'h70;
        key_pressed      = 1'b1;
        bus_address      = A_STAT;
        bus_write_data   = 64'h1;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
        key_pressed      = 1'b0;
        tick();
        chk("ovf_set_wins", 64'(overflow), 64'h1);
        for (int i = 0; i < 11; i++) begin
            rd(A_DATA, d, v);
            chk("partial_drain", d, 64'h100 | 64'(8'h60 + i));
        end
        rd(A_STAT, d, v);
        chk("count5_status", d, stat(5, 0, 1));
        chk("count5_irq", 64'(irq), 64'h1);

        ascii_code  = 8'h77;
        key_pressed = 1'b1;
        reset       = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("midreset_irq", 64'(irq), 64'h0);
        chk("midreset_ovf", 64'(overflow), 64'h0);
        chk("midreset_rdata", bus_read_data, 64'h0);
        rd(A_STAT, d, v);
        chk("held_key_no_push", d, stat(0, 0, 0));
        rd(A_CTRL, d, v);
        chk("midreset_ie", d, 64'h0);
        key_pressed = 1'b0;
        tick();
        press(8'h55, 3);
        rd(A_STAT, d, v);
        chk("repress_status", d, stat(1, 0, 0));
        rd(A_DATA, d, v);
        chk("repress_data", d, 64'h155);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
